// File: rtl/coherent_cache_ctrl.sv
// Snooping MSI coherence controller for one private cache (per-line state only).
// Define COHERENCE_MESI_EN to add the Exclusive state (MESI).
module coherent_cache_ctrl #(
  parameter int ADDR_W = 2,
  parameter int CPU_ID = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pr_valid_i,
  input  logic              pr_wr_i,
  input  logic [ADDR_W-1:0] pr_addr_i,
  output logic              pr_ready_o,
  output logic              pr_done_o,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic [2:0]        bus_msg_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic [2:0]        bus_msg_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic              data_valid_i,
  output logic              flush_o,
  output logic              shared_o,
  input  logic              shared_i
);
  localparam int NUM_LINES = 1 << ADDR_W;

  localparam logic [1:0] L_I = 2'd0;
  localparam logic [1:0] L_S = 2'd1;
  localparam logic [1:0] L_M = 2'd2;
`ifdef COHERENCE_MESI_EN
  localparam logic [1:0] L_E = 2'd3;
`endif

  localparam logic [2:0] M_RD   = 3'd1;
  localparam logic [2:0] M_RDX  = 3'd2;
  localparam logic [2:0] M_UPGR = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BUS, S_WAIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        line_q [NUM_LINES];
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;

  logic              cap;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [1:0]        loc_val;
  logic              snp_we;
  logic [1:0]        snp_val;
  logic [1:0]        pr_line, cur_line, snp_line, fill_val;
  logic              pr_hit;
  logic              unused;

  assign unused   = ^{shared_i, 1'(CPU_ID)};
  assign pr_line  = line_q[pr_addr_i];
  assign cur_line = line_q[addr_q];
  assign snp_line = line_q[bus_addr_i];

`ifdef COHERENCE_MESI_EN
  assign pr_hit   = pr_wr_i ? (pr_line == L_M || pr_line == L_E)
                            : (pr_line != L_I);
  assign fill_val = wr_q ? L_M : (shared_i ? L_S : L_E);
`else
  assign pr_hit   = pr_wr_i ? (pr_line == L_M) : (pr_line != L_I);
  assign fill_val = wr_q ? L_M : L_S;
`endif

  always_comb begin
    state_d    = state_q;
    cap        = 1'b0;
    loc_we     = 1'b0;
    loc_addr   = addr_q;
    loc_val    = L_M;
    pr_ready_o = 1'b0;
    pr_done_o  = 1'b0;
    bus_req_o  = 1'b0;
    bus_msg_o  = 3'd0;
    bus_addr_o = '0;
    unique case (state_q)
      S_IDLE: begin
        pr_ready_o = 1'b1;
        if (pr_valid_i) begin
          cap     = 1'b1;
          state_d = pr_hit ? S_DONE : S_REQ;
`ifdef COHERENCE_MESI_EN
          // silent E->M upgrade on a write hit
          if (pr_wr_i && pr_line == L_E) begin
            loc_we   = 1'b1;
            loc_addr = pr_addr_i;
          end
`endif
        end
      end
      S_REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_d = S_BUS;
      end
      S_BUS: begin
        bus_addr_o = addr_q;
        if (wr_q && cur_line == L_S) begin
          bus_msg_o = M_UPGR;
          loc_we    = 1'b1;
          state_d   = S_DONE;
        end else begin
          bus_msg_o = wr_q ? M_RDX : M_RD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_valid_i) begin
          loc_we  = 1'b1;
          loc_val = fill_val;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        pr_done_o = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    snp_we   = 1'b0;
    snp_val  = snp_line;
    flush_o  = 1'b0;
    shared_o = 1'b0;
    case (bus_msg_i)
      M_RD: begin
        shared_o = (snp_line != L_I);
        flush_o  = (snp_line == L_M);
        if (snp_line != L_I && snp_line != L_S) begin
          snp_we  = 1'b1;
          snp_val = L_S;
        end
      end
      M_RDX: begin
        flush_o = (snp_line == L_M);
        if (snp_line != L_I) begin
          snp_we  = 1'b1;
          snp_val = L_I;
        end
      end
      M_UPGR: begin
        if (snp_line == L_S) begin
          snp_we  = 1'b1;
          snp_val = L_I;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        wr_q   <= pr_wr_i;
        addr_q <= pr_addr_i;
      end
    end
  end

  // local update wins over a snoop to the same line
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_LINES; i++) line_q[i] <= L_I;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (loc_we && loc_addr == ADDR_W'(i))
          line_q[i] <= loc_val;
        else if (snp_we && bus_addr_i == ADDR_W'(i))
          line_q[i] <= snp_val;
      end
    end
  end

endmodule

// File: tb/tb_coherent_cache_ctrl.sv
// Directed self-checking bench for coherent_cache_ctrl.
// MESI section active when COHERENCE_MESI_EN is defined.
module tb_coherent_cache_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       pr_valid_i, pr_wr_i;
  logic [1:0] pr_addr_i;
  logic       pr_ready_o, pr_done_o, bus_req_o;
  logic       bus_gnt_i;
  logic [2:0] bus_msg_o, bus_msg_i;
  logic [1:0] bus_addr_o, bus_addr_i;
  logic       data_valid_i, flush_o, shared_o, shared_i;
  int         checks = 0;
  int         errors = 0;
  logic       fill_sh;

  localparam logic [1:0] LI = 2'd0;
  localparam logic [1:0] LS = 2'd1;
  localparam logic [1:0] LM = 2'd2;

  coherent_cache_ctrl #(.ADDR_W(2), .CPU_ID(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pr_valid_i(pr_valid_i), .pr_wr_i(pr_wr_i),
    .pr_addr_i(pr_addr_i),
    .pr_ready_o(pr_ready_o), .pr_done_o(pr_done_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
    .bus_msg_o(bus_msg_o), .bus_addr_o(bus_addr_o),
    .bus_msg_i(bus_msg_i), .bus_addr_i(bus_addr_i),
    .data_valid_i(data_valid_i), .flush_o(flush_o),
    .shared_o(shared_o), .shared_i(shared_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, pr_ready_o, 1'b1);
    chk({tag, "_done"}, pr_done_o, 1'b0);
    chk({tag, "_req"}, bus_req_o, 1'b0);
    chk({tag, "_msg"}, bus_msg_o, 3'd0);
    chk({tag, "_baddr"}, bus_addr_o, 2'd0);
    chk({tag, "_flush"}, flush_o, 1'b0);
    chk({tag, "_shared"}, shared_o, 1'b0);
  endtask

  task automatic miss_to_wait(input logic wr,
                              input logic [1:0] a);
    pr_valid_i = 1'b1; pr_wr_i = wr; pr_addr_i = a;
    step();
    pr_valid_i = 1'b0; bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    step();
  endtask

  initial begin
`ifdef COHERENCE_MESI_EN
    fill_sh = 1'b1;
`else
    fill_sh = 1'b0;
`endif
    rst_i = 1'b0; pr_valid_i = 0; pr_wr_i = 0;
    pr_addr_i = 0;
    bus_gnt_i = 0; bus_msg_i = 0; bus_addr_i = 0;
    data_valid_i = 0; shared_i = 0;
    #2;
    check_reset_outs("rst");
    for (int i = 0; i < 4; i++) begin
      chk("rst_line", dut.line_q[i], LI);
    end
    step(); step();
    rst_i = 1'b1;
    step();

    pr_valid_i = 1; pr_wr_i = 0; pr_addr_i = 2;
    #1;
    chk("rd_ready", pr_ready_o, 1'b1);
    step();
    pr_valid_i = 0;
    #1;
    chk("rd_req", bus_req_o, 1'b1);
    chk("rd_ready_lo", pr_ready_o, 1'b0);
    step();
    chk("rd_req_hold", bus_req_o, 1'b1);
    chk("rd_msg_nogrant", bus_msg_o, 3'd0);
    bus_gnt_i = 1;
    step();
    bus_gnt_i = 0;
    #1;
    chk("rd_msg", bus_msg_o, 3'd1);
    chk("rd_baddr", bus_addr_o, 2'd2);
    chk("rd_req_off", bus_req_o, 1'b0);
    step();
    chk("rd_msg_one", bus_msg_o, 3'd0);
    chk("rd_wait_done", pr_done_o, 1'b0);
    step();
    chk("rd_wait_hold", pr_done_o, 1'b0);
    data_valid_i = 1; shared_i = fill_sh;
    step();
    data_valid_i = 0; shared_i = 0;
    #1;
    chk("rd_done", pr_done_o, 1'b1);
    chk("rd_line2", dut.line_q[2], LS);
    step();
    chk("rd_done_pulse", pr_done_o, 1'b0);
    chk("rd_ready_back", pr_ready_o, 1'b1);

    pr_valid_i = 1; pr_wr_i = 1; pr_addr_i = 2;
    step();
    pr_valid_i = 0; bus_msg_i = 3'd2; bus_addr_i = 2;
    #1;
    chk("wr_snp_shared", shared_o, 1'b0);
    chk("wr_snp_flush", flush_o, 1'b0);
    step();
    bus_msg_i = 0; bus_addr_i = 0;
    chk("wr_line2_inv", dut.line_q[2], LI);
    bus_gnt_i = 1;
    step();
    bus_gnt_i = 0;
    #1;
    chk("wr_msg_rdx", bus_msg_o, 3'd2);
    step();
    data_valid_i = 1;
    step();
    data_valid_i = 0;
    #1;
    chk("wr_done", pr_done_o, 1'b1);
    chk("wr_line2_m", dut.line_q[2], LM);
    step();

    bus_msg_i = 3'd1; bus_addr_i = 2;
    #1;
    chk("snrd_flush", flush_o, 1'b1);
    chk("snrd_shared", shared_o, 1'b1);
    step();
    bus_msg_i = 0;
    #1;
    chk("snrd_line2_s", dut.line_q[2], LS);
    chk("snrd_noreq", bus_req_o, 1'b0);

    pr_valid_i = 1; pr_wr_i = 1; pr_addr_i = 2;
    step();
    pr_valid_i = 0; bus_gnt_i = 1;
    step();
    bus_gnt_i = 0; bus_msg_i = 3'd2; bus_addr_i = 2;
    #1;
    chk("upg_msg", bus_msg_o, 3'd3);
    chk("upg_baddr", bus_addr_o, 2'd2);
    chk("upg_flush", flush_o, 1'b0);
    step();
    bus_msg_i = 0;
    #1;
    chk("upg_done", pr_done_o, 1'b1);
    chk("upg_line2_m", dut.line_q[2], LM);
    step();

    miss_to_wait(1'b0, 2'd0);
    data_valid_i = 1; shared_i = 1;
    step();
    data_valid_i = 0; shared_i = 0;
    chk("rd0_line_s", dut.line_q[0], LS);
    step();

    pr_valid_i = 1; pr_wr_i = 1; pr_addr_i = 2;
    bus_msg_i = 3'd1; bus_addr_i = 0;
    #1;
    chk("par_shared", shared_o, 1'b1);
    chk("par_flush", flush_o, 1'b0);
    step();
    pr_valid_i = 0; bus_msg_i = 0;
    #1;
    chk("par_done", pr_done_o, 1'b1);
    chk("par_noreq", bus_req_o, 1'b0);
    chk("par_line0_s", dut.line_q[0], LS);
    chk("par_line2_m", dut.line_q[2], LM);
    step();

    bus_msg_i = 3'd5; bus_addr_i = 2; data_valid_i = 1;
    #1;
    chk("ign_flush", flush_o, 1'b0);
    step();
    bus_msg_i = 0; data_valid_i = 0;
    chk("ign_line2", dut.line_q[2], LM);
    chk("ign_done", pr_done_o, 1'b0);
    chk("ign_ready", pr_ready_o, 1'b1);

    bus_msg_i = 3'd2; bus_addr_i = 2;
    #1;
    chk("snrdx_flush", flush_o, 1'b1);
    chk("snrdx_shared", shared_o, 1'b0);
    step();
    bus_msg_i = 0;
    chk("snrdx_line2_i", dut.line_q[2], LI);

    miss_to_wait(1'b0, 2'd3);
    chk("rw_in_wait", pr_ready_o, 1'b0);
    rst_i = 0;
    #1;
    check_reset_outs("rw");
    chk("rw_line0_i", dut.line_q[0], LI);
    data_valid_i = 1;
    step();
    rst_i = 1;
    step();
    data_valid_i = 0;
    chk("rw_nodone1", pr_done_o, 1'b0);
    step();
    chk("rw_nodone2", pr_done_o, 1'b0);
    chk("rw_line3_i", dut.line_q[3], LI);

`ifdef COHERENCE_MESI_EN
    miss_to_wait(1'b0, 2'd3);
    data_valid_i = 1; shared_i = 0;
    step();
    data_valid_i = 0;
    chk("mesi_line3_e", dut.line_q[3], 2'd3);
    step();
    pr_valid_i = 1; pr_wr_i = 1; pr_addr_i = 3;
    #1;
    chk("mesi_ready", pr_ready_o, 1'b1);
    step();
    pr_valid_i = 0;
    #1;
    chk("mesi_done", pr_done_o, 1'b1);
    chk("mesi_noreq", bus_req_o, 1'b0);
    chk("mesi_line3_m", dut.line_q[3], LM);
    step();
`else
    miss_to_wait(1'b0, 2'd3);
    data_valid_i = 1; shared_i = 0;
    step();
    data_valid_i = 0;
    chk("msi_line3_s", dut.line_q[3], LS);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
